// File: rtl/aes_state_display_seq_pkg.sv
// ============================================================================
// Module : aes_state_display_seq_pkg
// Brief  : Shared display constants, FSM encoding and byte/segment helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aes_state_display_seq_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  // Byte 0 is the most significant byte; ~i equals 15-i for a 4-bit index
  function automatic logic [7:0] state_byte(input logic [127:0] s, input logic [3:0] i);
    return s[{~i, 3'b000} +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_state_display_seq_hex_to_7seg.sv
// ============================================================================
// Module : hex_to_7seg
// Brief  : 4-bit value to active-low 7-segment hex digit (0-9, A, b, C, d, E, F).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hex_to_7seg
  import aes_state_display_seq_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_seg(hex_i);

endmodule

`default_nettype wire

// File: rtl/binaryToSevenSegment.sv
// ============================================================================
// Module : binaryToSevenSegment
// Brief  : 8-bit binary to three active-low decimal 7-segment digits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module binaryToSevenSegment
  import aes_state_display_seq_pkg::*;
(
  input  logic [7:0] bin_i,
  output logic [6:0] seg_hundreds_o,
  output logic [6:0] seg_tens_o,
  output logic [6:0] seg_ones_o
);

  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  assign hundreds = 4'(bin_i / 8'd100);
  assign tens     = 4'((bin_i / 8'd10) % 8'd10);
  assign ones     = 4'(bin_i % 8'd10);

  assign seg_hundreds_o = hex_seg(hundreds);
  assign seg_tens_o     = hex_seg(tens);
  assign seg_ones_o     = hex_seg(ones);

endmodule

`default_nettype wire

// File: rtl/aes_state_display_seq.sv
// ============================================================================
// Module : aes_state_display_seq
// Brief  : Steps a captured 128-bit AES state byte-by-byte onto 7-seg displays.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_state_display_seq
  import aes_state_display_seq_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  input  logic         pause,
  input  logic         step,
  output logic         busy,
  output logic         done,
  output logic [3:0]   byte_idx,
  output logic [7:0]   byte_val,
  output logic [6:0]   seg_hundreds,
  output logic [6:0]   seg_tens,
  output logic [6:0]   seg_ones,
  output logic [6:0]   seg_idx
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [3:0]         idx_q,    idx_d;
  logic [7:0]         val_q,    val_d;
  logic [127:0]       shadow_q, shadow_d;
  logic               advance;
  logic [6:0]         conv_h, conv_t, conv_o, conv_idx;
  logic               show;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      val_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      shadow_q <= shadow_d;
    end
  end

  // A step and a dwell expiry in the same cycle collapse into one advance
  assign advance = step || (!pause && (cnt_q == DWELL_LAST));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    val_d    = val_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d = state_in;
          idx_d    = 4'd0;
          val_d    = state_byte(state_in, 4'd0);
          cnt_d    = '0;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (advance) begin
          cnt_d = '0;
          if (idx_q == 4'hF) begin
            state_d = ST_FINISH;
          end else begin
            idx_d = idx_q + 4'd1;
            val_d = state_byte(shadow_q, idx_q + 4'd1);
          end
        end else if (!pause) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  binaryToSevenSegment u_dec (
    .bin_i          (val_q),
    .seg_hundreds_o (conv_h),
    .seg_tens_o     (conv_t),
    .seg_ones_o     (conv_o)
  );

  hex_to_7seg u_idx (
    .hex_i (idx_q),
    .seg_o (conv_idx)
  );

  // FINISH keeps the last byte on screen for its single cycle
  assign show         = (state_q != ST_IDLE);
  assign busy         = (state_q == ST_SHOW);
  assign done         = (state_q == ST_FINISH);
  assign byte_idx     = idx_q;
  assign byte_val     = val_q;
  assign seg_hundreds = show ? conv_h   : SEG_BLANK;
  assign seg_tens     = show ? conv_t   : SEG_BLANK;
  assign seg_ones     = show ? conv_o   : SEG_BLANK;
  assign seg_idx      = show ? conv_idx : SEG_BLANK;

endmodule

`default_nettype wire

// File: tb/tb_aes_state_display_seq.sv
// ============================================================================
// Module : tb_aes_state_display_seq
// Brief  : Scoreboard bench for aes_state_display_seq with DWELL_CYCLES=4.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aes_state_display_seq;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] idx;
    logic [7:0] val;
    int         gap;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] state_in = '0;
  logic         pause = 1'b0;
  logic         step = 1'b0;
  logic         busy, done;
  logic [3:0]   byte_idx;
  logic [7:0]   byte_val;
  logic [6:0]   seg_hundreds, seg_tens, seg_ones, seg_idx;

  int checks = 0;
  int errors = 0;
  ev_t ev_q[$];
  int  done_q[$];
  bit  scramble = 1'b0;

  aes_state_display_seq #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .state_in     (state_in),
    .pause        (pause),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .byte_idx     (byte_idx),
    .byte_val     (byte_val),
    .seg_hundreds (seg_hundreds),
    .seg_tens     (seg_tens),
    .seg_ones     (seg_ones),
    .seg_idx      (seg_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] dec_segs(input logic [7:0] v);
    return {SEG_TAB[v / 100], SEG_TAB[(v / 10) % 10], SEG_TAB[v % 10]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
    return s[127 - 8*k -: 8];
  endfunction

  // Monitor: pops an expectation every time a new byte appears or done pulses
  int         cyc = 0;
  int         last_ev = 0;
  int         rise_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [3:0] idx_prev = '0;
  logic [7:0] last_val = '0;

  always @(negedge clk) begin
    ev_t e;
    int  lat;
    cyc++;
    if (busy === 1'b1 && (!busy_prev || byte_idx !== idx_prev)) begin
      if (!busy_prev) rise_cyc = cyc;
      if (ev_q.size() == 0) begin
        chk("ev_unexpected", 32'd1, 32'd0);
      end else begin
        e = ev_q.pop_front();
        last_val = e.val;
        chk("ev_idx", 32'(byte_idx), 32'(e.idx));
        chk("ev_val", 32'(byte_val), 32'(e.val));
        chk("ev_dec_segs", 32'({seg_hundreds, seg_tens, seg_ones}), 32'(dec_segs(e.val)));
        chk("ev_seg_idx", 32'(seg_idx), 32'(SEG_TAB[e.idx]));
        if (e.gap != 0) chk("ev_dwell", 32'(cyc - last_ev), 32'(e.gap));
      end
      last_ev = cyc;
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        lat = done_q.pop_front();
        chk("done_latency", 32'(cyc - rise_cyc), 32'(lat));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_idx", 32'(byte_idx), 32'd15);
        chk("done_segs", 32'({seg_hundreds, seg_tens, seg_ones}), 32'(dec_segs(last_val)));
      end
    end else if (busy !== 1'b1) begin
      chk("idle_blank", 32'({seg_hundreds, seg_tens, seg_ones, seg_idx}), 32'({4{7'h7F}}));
    end
    busy_prev = busy;
    idx_prev  = byte_idx;
  end

  task automatic wait_idx(input logic [3:0] t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy === 1'b1 && byte_idx === t) && n < 300);
    if (n >= 300) chk("wait_idx_timeout", 32'(byte_idx), 32'(t));
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 300);
    if (n >= 300) chk("wait_done_timeout", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_idx"},  32'(byte_idx), 32'd0);
    chk({tag, "_val"},  32'(byte_val), 32'd0);
    chk({tag, "_segs"}, 32'({seg_hundreds, seg_tens, seg_ones, seg_idx}), 32'({4{7'h7F}}));
  endtask

  // Scrambles state_in away from the sampling edges while a sequence runs
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (scramble) state_in = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  localparam logic [127:0] SA = 128'h00FF7B09_11223344_55667788_99AABB0A;
  localparam logic [127:0] SB = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] SC = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

  initial begin
    logic [127:0] s;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Sequence A: plain dwell, start while busy ignored, state_in scrambled
    s = SA;
    for (int k = 0; k < 16; k++) ev_q.push_back('{idx: 4'(k), val: byte_of(s, k), gap: (k == 0) ? 0 : 4});
    done_q.push_back(64);
    state_in = SA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble = 1'b1;
    chk("a_busy_after_start", 32'(busy), 32'd1);
    chk("a_byte0_segs", 32'({seg_hundreds, seg_tens, seg_ones, seg_idx}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    wait_idx(4'd1);
    chk("a_byte1_255", 32'({seg_hundreds, seg_tens, seg_ones}), 32'({7'h24, 7'h12, 7'h12}));
    wait_idx(4'd2);
    chk("a_byte2_123", 32'({seg_hundreds, seg_tens, seg_ones}), 32'({7'h79, 7'h24, 7'h30}));
    wait_idx(4'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start held through FINISH (ignored) into the first IDLE cycle (accepted)
    scramble = 1'b0;
    s = SB;
    for (int k = 0; k < 16; k++) begin
      int g;
      g = (k == 0) ? 0 : (k == 4) ? 14 : (k == 5) ? 3 : 4;
      ev_q.push_back('{idx: 4'(k), val: byte_of(s, k), gap: g});
    end
    done_q.push_back(73);
    state_in = SB;
    start = 1'b1;
    @(negedge clk);
    chk("start_in_finish_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("start_in_idle_accepted", 32'(busy), 32'd1);

    // Sequence B: pause during byte 3, step while paused on byte 4, step on expiry at byte 6
    wait_idx(4'd3);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    pause = 1'b0;
    wait_idx(4'd4);
    pause = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    pause = 1'b0;
    chk("step_while_paused", 32'(byte_idx), 32'd5);
    wait_idx(4'd6);
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_on_expiry_single", 32'(byte_idx), 32'd7);
    wait_done();
    @(negedge clk);

    // Sequence C: reset asserted mid-sequence at byte 7
    s = SC;
    for (int k = 0; k < 8; k++) ev_q.push_back('{idx: 4'(k), val: byte_of(s, k), gap: (k == 0) ? 0 : 4});
    state_in = SC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(4'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ev_queue_empty", 32'(ev_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
